// File: rtl/prg_uploader.sv
// prg_uploader
//   Reads the BASIC END pointer out of RAM, derives the program length and
//   streams the PRG bytes to the host through a valid/ready handshake. While
//   busy it owns the RAM port. The top level holds the CPU in reset during that time.
//
//   Optional feature macro: UPLOADER_HEADER_EN
//     defined     : the stream starts with a 2-byte length header (lo, hi)
//     not defined : only PRG bytes are sent, and out_idx starts at 0
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   ena             clock enable; nothing advances while low
//   start, abort    begin / cancel an upload (abort wins)
//   busy, done, err status: busy, 1-cycle completion pulse, sticky bad END ptr
//   length          computed program length in bytes
//   mem_rd/addr     RAM read strobe and address
//   mem_dout        RAM read data, valid one enabled cycle after mem_rd
//   out_*           byte stream: valid/ready, data, index within the stream
module prg_uploader #(
  parameter logic [24:0] PRG_START_ADDR = 25'h10995,
  parameter logic [24:0] PTR_PROGND     = 25'h103E9,
  parameter logic [15:0] PTR_END_BASE   = 16'h8995
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] length,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic [7:0]  mem_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [15:0] out_idx
);

  typedef enum logic [3:0] {
    IDLE, PLO, PLOW, PHI, PHIW, CALC, RD, RDW, PRES, DONE
  } state_t;

`ifdef UPLOADER_HEADER_EN
  localparam logic [15:0] IDX_OFS = 16'd2;
  logic hdr_phase;  // PRES is presenting a header byte
  logic hdr_hi;     // the header byte being presented is the high byte
`else
  localparam logic [15:0] IDX_OFS = 16'd0;
`endif

  state_t      state;
  logic [15:0] end_ptr;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] diff;
  logic        under_base;
  logic [15:0] len_calc;

  always_comb begin
    cnt_inc    = cnt + 16'd1;
    diff       = end_ptr - PTR_END_BASE;
    under_base = end_ptr < PTR_END_BASE;
    len_calc   = under_base ? '0 : diff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      length    <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      end_ptr   <= '0;
      cnt       <= '0;
`ifdef UPLOADER_HEADER_EN
      hdr_phase <= 1'b0;
      hdr_hi    <= 1'b0;
`endif
    end else if (ena) begin
      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        mem_rd    <= 1'b0;
        out_valid <= 1'b0;
`ifdef UPLOADER_HEADER_EN
        hdr_phase <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
            if (start && !abort) begin
              state    <= PLO;
              busy     <= 1'b1;
              err      <= 1'b0;
              length   <= '0;
              cnt      <= '0;
              mem_rd   <= 1'b1;
              mem_addr <= PTR_PROGND;
            end
          end
          PLO: begin
            mem_rd <= 1'b0;
            state  <= PLOW;
          end
          PLOW: begin
            end_ptr[7:0] <= mem_dout;
            mem_rd       <= 1'b1;
            mem_addr     <= PTR_PROGND + 25'd1;
            state        <= PHI;
          end
          PHI: begin
            mem_rd <= 1'b0;
            state  <= PHIW;
          end
          PHIW: begin
            end_ptr[15:8] <= mem_dout;
            state         <= CALC;
          end
          CALC: begin
            err    <= under_base;
            length <= len_calc;
`ifdef UPLOADER_HEADER_EN
            out_data  <= len_calc[7:0];
            out_idx   <= '0;
            out_valid <= 1'b1;
            hdr_phase <= 1'b1;
            hdr_hi    <= 1'b0;
            state     <= PRES;
`else
            if (len_calc == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= PRG_START_ADDR + {9'd0, cnt};
              state    <= RD;
            end
`endif
          end
          RD: begin
            mem_rd <= 1'b0;
            state  <= RDW;
          end
          RDW: begin
            out_data  <= mem_dout;
            out_idx   <= cnt + IDX_OFS;
            out_valid <= 1'b1;
            state     <= PRES;
          end
          PRES: begin
            if (out_ready) begin
              out_valid <= 1'b0;
`ifdef UPLOADER_HEADER_EN
              if (hdr_phase) begin
                if (!hdr_hi) begin
                  out_data  <= length[15:8];
                  out_idx   <= 16'd1;
                  out_valid <= 1'b1;
                  hdr_hi    <= 1'b1;
                end else begin
                  hdr_phase <= 1'b0;
                  if (length == '0) begin
                    done  <= 1'b1;
                    state <= DONE;
                  end else begin
                    mem_rd   <= 1'b1;
                    mem_addr <= PRG_START_ADDR + {9'd0, cnt};
                    state    <= RD;
                  end
                end
              end else
`endif
              begin
                cnt <= cnt_inc;
                if (cnt_inc == length) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= PRG_START_ADDR + {9'd0, cnt_inc};
                  state    <= RD;
                end
              end
            end
          end
          DONE: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prg_uploader.sv
module tb_prg_uploader;

`ifdef UPLOADER_HEADER_EN
  localparam int HOFS = 2;
  localparam int LAT  = 5;
`else
  localparam int HOFS = 0;
  localparam int LAT  = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err, mem_rd, out_valid, out_ready;
  logic [15:0] length, out_idx;
  logic [24:0] mem_addr;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  out_data;

  logic ena_mode = 1'b0;
  logic tog_mode = 1'b0;
  logic ready_lvl = 1'b1;
  int unsigned cyc = 0;

  logic [7:0] ptr_lo, ptr_hi;
  logic [7:0] prg [0:7];

  int n_chk = 0;
  int n_fail = 0;

  prg_uploader dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .length(length),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ena       = ena_mode ? (cyc % 4 == 0) : 1'b1;
  assign out_ready = tog_mode ? ((cyc / 3) % 2 == 0) : ready_lvl;

  function automatic logic [7:0] ram_rd(input logic [24:0] a);
    if (a == 25'h103E9) return ptr_lo;
    if (a == 25'h103EA) return ptr_hi;
    if (a >= 25'h10995 && a < 25'h1099D) return prg[3'(a - 25'h10995)];
    return 8'hEE;
  endfunction

  always @(posedge clk) if (ena && mem_rd) mem_dout <= ram_rd(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream monitor sampling on the falling edge
  logic [7:0]  cap_d[$];
  logic [15:0] cap_i[$];
  int   done_cnt = 0;
  logic done_q = 1'b0, busy_q = 1'b0, seen_valid = 1'b0, seen_busy = 1'b0;
  int   first_valid_cyc = 0, busy_cyc = 0;
  logic pv = 1'b0, pacc = 1'b0, pab = 1'b1;
  logic [7:0]  pd = '0;
  logic [15:0] pi = '0;

  always @(negedge clk) begin
    if (out_valid && out_ready && ena) begin
      cap_d.push_back(out_data);
      cap_i.push_back(out_idx);
    end
    if (done && !done_q) done_cnt++;
    if (out_valid && !seen_valid) begin seen_valid = 1'b1; first_valid_cyc = int'(cyc); end
    if (busy && !busy_q && !seen_busy) begin seen_busy = 1'b1; busy_cyc = int'(cyc); end
    if (pv && !pacc && !pab && !reset)
      chk("hold", {7'd0, out_valid, out_data, out_idx}, {7'd0, 1'b1, pd, pi});
    pv = out_valid; pacc = out_valid && out_ready && ena; pab = abort || reset;
    pd = out_data; pi = out_idx; done_q = done; busy_q = busy;
  end

  task automatic do_start();
    int k = 0;
    start = 1'b1;
    while (!busy && k < 100) begin @(posedge clk); #1; k++; end
    start = 1'b0;
    if (!busy) chk("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin @(posedge clk); #1; k++; end
    if (busy) chk("idle_timeout", 32'd0, 32'd1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int idx);
    int k = 0;
    while (!(out_valid && out_idx == 16'(idx)) && k < 500) begin @(posedge clk); #1; k++; end
    if (!(out_valid && out_idx == 16'(idx))) chk("idx_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int base, input logic [7:0] exp[$]);
    chk({tag, "_cnt"}, 32'(cap_d.size() - base), 32'(exp.size()));
    foreach (exp[k]) if (base + k < cap_d.size()) begin
      chk({tag, "_dat"}, 32'(cap_d[base + k]), 32'(exp[k]));
      chk({tag, "_idx"}, 32'(cap_i[base + k]), 32'(k));
    end
  endtask

  initial begin
    logic [7:0] exp4[$];
    logic [7:0] exp0[$];
    int base, dbase;
`ifdef UPLOADER_HEADER_EN
    exp4 = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    exp0.push_back(8'h00);
    exp0.push_back(8'h00);
`else
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    prg[0] = 8'h11; prg[1] = 8'h22; prg[2] = 8'h33; prg[3] = 8'h44;
    prg[4] = 8'h55; prg[5] = 8'h66; prg[6] = 8'h77; prg[7] = 8'h88;
    ptr_lo = 8'h99; ptr_hi = 8'h89;

    #1;
    chk("rst_outs", {busy, done, err, mem_rd, out_valid, 1'b0, length, 8'h00},
                    32'd0);
    chk("rst_bus", {7'd0, mem_addr}, 32'd0);
    chk("rst_data", {8'd0, out_data, out_idx}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4-byte upload, ready held high
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    chk_stream("basic", base, exp4);
    chk("basic_len", 32'(length), 32'd4);
    chk("basic_done", 32'(done_cnt - dbase), 32'd1);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_lat", 32'(first_valid_cyc - busy_cyc), 32'(LAT));

    // END equals base: zero length
    ptr_lo = 8'h95; ptr_hi = 8'h89;
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    chk_stream("zero", base, exp0);
    chk("zero_len", 32'(length), 32'd0);
    chk("zero_done", 32'(done_cnt - dbase), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

    // END below base: error
    ptr_lo = 8'h00; ptr_hi = 8'h80;
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    chk_stream("under", base, exp0);
    chk("under_len", 32'(length), 32'd0);
    chk("under_done", 32'(done_cnt - dbase), 32'd1);
    chk("under_err", 32'(err), 32'd1);

    // ready toggling; next start also clears err
    ptr_lo = 8'h99; ptr_hi = 8'h89;
    tog_mode = 1'b1;
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    chk("err_cleared", 32'(err), 32'd0);
    wait_idle();
    tog_mode = 1'b0;
    chk_stream("toggle", base, exp4);
    chk("toggle_done", 32'(done_cnt - dbase), 32'd1);

    // abort while byte 2 is presented
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idx(HOFS + 1);
    abort = 1'b1; ready_lvl = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done_cnt - dbase), 32'd0);
    chk("abort_bytes", 32'(cap_d.size() - base), 32'(HOFS + 1));
    ready_lvl = 1'b1;
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    chk_stream("restart", base, exp4);
    chk("restart_done", 32'(done_cnt - dbase), 32'd1);

    // sparse clock enable
    ena_mode = 1'b1;
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    ena_mode = 1'b0;
    chk_stream("ena", base, exp4);
    chk("ena_done", 32'(done_cnt - dbase), 32'd1);

    // asynchronous reset mid-stream
    do_start();
    wait_idx(HOFS + 1);
    reset = 1'b1;
    #1;
    chk("mrst_outs", {busy, done, err, mem_rd, out_valid, 1'b0, length, 8'h00}, 32'd0);
    chk("mrst_bus", {7'd0, mem_addr}, 32'd0);
    chk("mrst_data", {8'd0, out_data, out_idx}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_idle", {30'd0, busy, out_valid}, 32'd0);
    base = cap_d.size(); dbase = done_cnt;
    do_start();
    wait_idle();
    chk_stream("post_rst", base, exp4);
    chk("post_rst_done", 32'(done_cnt - dbase), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
